muldiv_ctrl: RTL

Sequencer for the iterative multiply/divide datapath behind HI/LO in the 5-stage pipeline. It accepts mult/div issue from the E stage and steps the datapath for a fixed cycle count. It then pulses the HI/LO write. While the unit is busy it raises a decode-stage interlock for any HI/LO consumer or producer, which the pipeline ORs into StallF/StallD/FlushE.

---
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Issue/interlock/datapath-control bundle between the pipeline and the mult/div sequencer.
// slave = sequencer side, master = pipeline/datapath side.
interface muldiv_if;
  logic        StartMulE;
  logic        StartDivE;
  logic        SignedE;
  logic        FlushE;
  logic        Abort;
  logic        HiLoUseD;
  logic        StallMD;
  logic        Busy;
  logic        DpStart;
  logic        DpStep;
  logic        DpIsDiv;
  logic        DpSigned;
  logic        HiLoWe;
  logic [31:0] StallCount;
  logic [1:0]  dbgState;

  modport slave (
    input  StartMulE, StartDivE, SignedE, FlushE, Abort, HiLoUseD,
    output StallMD, Busy, DpStart, DpStep, DpIsDiv, DpSigned, HiLoWe,
    output StallCount, dbgState
  );

  modport master (
    output StartMulE, StartDivE, SignedE, FlushE, Abort, HiLoUseD,
    input  StallMD, Busy, DpStart, DpStep, DpIsDiv, DpSigned, HiLoWe,
    input  StallCount, dbgState
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative HI/LO multiply/divide datapath with decode interlock.
// Optional stall performance counter enabled by defining MULDIV_PERF_EN.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  md
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             accept;
  logic             dpStartQ;
  logic             dpIsDivQ;
  logic             dpSignedQ;
  logic             busyQ;
  logic             stallMd;

  // Start handshake: a start is taken (accept) only in IDLE, when the E slot is
  // not a bubble and no abort is pending; there is no back-pressure to E, the
  // D-stage interlock (StallMD) is what keeps dependent ops from advancing.
  always_comb begin
    accept    = (state == IDLE) & (md.StartMulE | md.StartDivE) & ~md.FlushE & ~md.Abort;
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = RUN;
          cntNext   = md.StartDivE ? DIV_LOAD : MUL_LOAD;
        end
      end
      RUN: begin
        if (md.Abort) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else if (cnt == '0) begin
          stateNext = DONE;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dpStartQ  <= 1'b0;
      dpIsDivQ  <= 1'b0;
      dpSignedQ <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      dpStartQ <= accept;
      busyQ    <= (stateNext != IDLE);
      // Divide wins when both starts are raised together.
      if (accept) begin
        dpIsDivQ  <= md.StartDivE;
        dpSignedQ <= md.SignedE;
      end
    end
  end

  // Abort and reset suppress the step and the write in the very cycle they appear.
  assign stallMd     = md.HiLoUseD & (busyQ | accept);
  assign md.StallMD  = stallMd;
  assign md.Busy     = busyQ;
  assign md.DpStart  = dpStartQ;
  assign md.DpStep   = (state == RUN)  & ~md.Abort & ~rst;
  assign md.HiLoWe   = (state == DONE) & ~md.Abort & ~rst;
  assign md.DpIsDiv  = dpIsDivQ;
  assign md.DpSigned = dpSignedQ;
  assign md.dbgState = state;

`ifdef MULDIV_PERF_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (stallMd && (stallCnt != 32'hFFFF_FFFF)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign md.StallCount = stallCnt;
`else
  assign md.StallCount = 32'd0;
`endif

endmodule
